// File: rtl/wb_grf.sv
// Writeback-side general-purpose register file: 31 writable registers, two
// combinational read ports with optional write bypass, plus trace and commit count.
module wb_grf #(
  parameter bit BYPASS     = 1'b1,
  parameter bit TRACE_ZERO = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [31:0] wpc,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2,
  output logic        trace_valid,
  output logic [31:0] trace_pc,
  output logic [4:0]  trace_addr,
  output logic [31:0] trace_data,
  output logic [31:0] wcount
);

  logic [31:0] regs [1:31];
  logic        commit;
  logic        traced;

  assign commit = we && (waddr != 5'd0);
  assign traced = commit || ((TRACE_ZERO == 1'b1) && we);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 1; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else if (commit) begin
      regs[waddr] <= wdata;
    end
  end

  // Reads are gated by reset so the bypass cannot leak wdata while held in reset.
  always_comb begin
    rdata1 = '0;
    if (reset && (raddr1 != 5'd0)) begin
      if ((BYPASS == 1'b1) && we && (waddr == raddr1)) rdata1 = wdata;
      else                                             rdata1 = regs[raddr1];
    end
  end

  always_comb begin
    rdata2 = '0;
    if (reset && (raddr2 != 5'd0)) begin
      if ((BYPASS == 1'b1) && we && (waddr == raddr2)) rdata2 = wdata;
      else                                             rdata2 = regs[raddr2];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      trace_valid <= 1'b0;
      trace_pc    <= '0;
      trace_addr  <= '0;
      trace_data  <= '0;
    end else begin
      trace_valid <= traced;
      if (traced) begin
        trace_pc   <= wpc;
        trace_addr <= waddr;
        trace_data <= commit ? wdata : 32'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      wcount <= '0;
    else if (commit) wcount <= wcount + 32'd1;
  end

endmodule

// File: doc/wb_grf.md
# wb_grf

General-purpose register file at the consuming end of the writeback path. It accepts the selected writeback word (ALU result or data-memory load) with its destination register and PC, and commits it to one of 31 writable 32-bit registers. It serves two combinational read ports to the decode stage, with an optional same-cycle write-to-read bypass. It also emits a registered one-cycle writeback trace record and a running count of committed writes for the verification environment.

## Interface
Parameters:
- BYPASS, 1: 1 = a read of the register being written this cycle returns `wdata`; 0 = it returns the stored value.
- TRACE_ZERO, 0: 1 = write attempts to $0 still produce a trace record; 0 = they are suppressed.

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset; low clears all state immediately.
- we  input  1  write enable for the writeback word.
- waddr  input  5  destination register number.
- wdata  input  32  writeback data from the writeback select.
- wpc  input  32  PC of the instruction being written back (trace only).
- raddr1, raddr2  input  5 each  read addresses.
- rdata1, rdata2  output  32 each  read data (combinational).
- trace_valid  output  1  one-cycle pulse, trace record valid.
- trace_pc  output  32  PC of the committed write.
- trace_addr  output  5  register written.
- trace_data  output  32  value written.
- wcount  output  32  number of committed writes since reset.

## Operation
- Storage: registers 1..31, 32 bits each. $0 has no storage and always reads 0.
- A commit occurs on a rising edge with reset high, we=1 and waddr≠0; reg[waddr] takes wdata.
- we=1 with waddr=0 changes no register and does not increment wcount. It produces a trace record only when TRACE_ZERO=1, and that record has trace_data=0.
- Reads: rdataN = 0 if raddrN=0.
  - Otherwise, if BYPASS=1 and we=1 and waddr=raddrN, then rdataN = wdata.
  - Otherwise, rdataN = reg[raddrN].
  - Both ports are independent; the same address on both ports returns identical data.
- Trace: on each commit edge, trace_valid←1, trace_pc←wpc, trace_addr←waddr, trace_data←wdata.
  - On edges with no commit (and no traced $0 write), trace_valid←0. trace_pc/addr/data then hold their last values.
- wcount increments by 1 per commit and wraps from 0xFFFFFFFF to 0x00000000 with no flag.
- Reset (reset low, asynchronous):
  - All 31 registers = 0.
  - trace_valid=0, trace_pc=0, trace_addr=0, trace_data=0, wcount=0.
  - rdata1/rdata2 = 0 for every address, independent of we and the bypass.
- While reset is low, we is ignored. The first commit possible is the first rising edge after reset goes high.
- Reset asserted between edges discards nothing already committed except by clearing it. There is no partial-write state.

## Timing
- Write latency: 1 edge. Data is visible through storage after the commit edge; with BYPASS=1 it is visible in the same cycle, combinationally.
- Read latency: 0 cycles (combinational path from raddr, we, waddr, wdata).
- Trace latency: trace_valid is high for exactly the one cycle following each commit edge. Back-to-back commits keep it high continuously, with a new record each cycle.
- wcount updates on the commit edge; its new value is visible in the same cycle as the matching trace_valid.
- Simultaneous read and write of the same register with BYPASS=0: the read returns the old value before the edge and the new value after it.
- No handshake; the writeback stage never stalls this block.

## Test plan
- Reset, then read all 32 addresses on both ports -> every read returns 0; trace_valid=0; wcount=0.
- we=1, waddr=5, wdata=0xDEADBEEF, wpc=0x00003000, one edge -> rdata1(raddr1=5)=0xDEADBEEF; trace_valid=1 for one cycle with pc=0x3000, addr=5, data=0xDEADBEEF; wcount=1.
- BYPASS=1: drive we=1, waddr=7, wdata=0x12345678, raddr2=7 before the edge -> rdata2=0x12345678 in the same cycle. BYPASS=0 -> rdata2 stays 0 until after the edge.
- we=1, waddr=0, wdata=0xFFFFFFFF -> rdata1(raddr1=0)=0, wcount unchanged. trace_valid=0 when TRACE_ZERO=0; trace_valid=1 with trace_data=0 when TRACE_ZERO=1.
- Commits to $1..$31 on consecutive edges -> trace_valid held high for 31 cycles, then low; wcount=31; each register holds its own value.
- Pull reset low mid-cycle after writing $3=0x55 -> rdata($3)=0, wcount=0 and trace_valid=0 immediately, without waiting for a clk edge.
